// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: word size and FSM state encoding.
package spi_pkg;

    // Bits per SPI frame on the FPGA link.
    localparam int SPI_WORD_BITS = 24;

    // Width of the frame bit counter; 2**SPI_CNT_W must exceed SPI_WORD_BITS.
    localparam int SPI_CNT_W = 6;

    // Frame FSM states.
    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_target_rx_sync_2ff.sv
// Two-flop synchroniser for slow asynchronous inputs, with a per-bit reset value.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Capture the asynchronous input and let it settle through a second flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/spi_target_rx.sv
// SPI mode-0 responder: receives fixed-length MSB-first words, raises a sticky
// interrupt per complete word and returns a status word on MISO in the same frame.
// All SPI pins are oversampled in the clk domain.
module spi_target_rx
    import spi_pkg::*;
#(
    parameter int DATA_BITS = SPI_WORD_BITS,
    parameter int CNT_W     = SPI_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclk,
    input  logic                 cs_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 miso_oe,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_interrupt,
    input  logic                 rx_interrupt_clear,
    output logic                 overrun,
    output logic                 frame_err
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Synchronised pins (two flops each).
    logic [1:0] sm_sync_s;
    logic       sclk_s;
    logic       mosi_s;
    logic       cs_s;

    // Third stage for edge detection.
    logic       sclk_d_r;
    logic       cs_d_r;
    logic       sclk_rise_s;
    logic       sclk_fall_s;
    logic       cs_rise_s;
    logic       cs_fall_s;

    // Frame state.
    spi_state_t           state_r;
    logic [1:0]           arm_cnt_r;
    logic [DATA_BITS-1:0] rx_sr_r;
    logic [DATA_BITS-2:0] tx_sr_r;
    logic [CNT_W-1:0]     cnt_r;

    // Output registers.
    logic                 miso_r;
    logic                 miso_oe_r;
    logic [DATA_BITS-1:0] rx_data_r;
    logic                 rx_int_r;
    logic                 overrun_r;
    logic                 frame_err_r;

    // Values after the current cycle's sclk edge, used so a coincident cs_n
    // rise evaluates the frame with the updated count and shift register.
    logic [CNT_W-1:0]     cnt_next_s;
    logic [DATA_BITS-1:0] rx_sr_next_s;
    logic                 frame_end_s;
    logic                 word_done_s;

    sync_2ff #(
        .WIDTH   (2),
        .RST_VAL (2'b00)
    ) u_sync_sclk_mosi (
        .clk (clk),
        .rst (rst),
        .d   ({sclk, mosi}),
        .q   (sm_sync_s)
    );

    // cs_n resets to the deselected level so no false edge appears at reset.
    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync_cs (
        .clk (clk),
        .rst (rst),
        .d   (cs_n),
        .q   (cs_s)
    );

    assign sclk_s = sm_sync_s[1];
    assign mosi_s = sm_sync_s[0];

    // Delay the synchronised sclk and cs_n by one more cycle for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_d_r <= 1'b0;
            cs_d_r   <= 1'b1;
        end else begin
            sclk_d_r <= sclk_s;
            cs_d_r   <= cs_s;
        end
    end

    assign sclk_rise_s = sclk_s & ~sclk_d_r;
    assign sclk_fall_s = ~sclk_s & sclk_d_r;
    assign cs_rise_s   = cs_s & ~cs_d_r;
    assign cs_fall_s   = ~cs_s & cs_d_r;

    // Apply this cycle's sclk rising edge to the count and receive shifter.
    always_comb begin
        cnt_next_s   = cnt_r;
        rx_sr_next_s = rx_sr_r;
        if (sclk_rise_s) begin
            rx_sr_next_s = {rx_sr_r[DATA_BITS-2:0], mosi_s};
            if (cnt_r != CNT_MAX) begin
                cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_next_s = cnt_r;
            end
        end else begin
            cnt_next_s   = cnt_r;
            rx_sr_next_s = rx_sr_r;
        end
    end

    assign frame_end_s = (state_r == ST_SHIFT) && cs_rise_s;
    assign word_done_s = frame_end_s && (cnt_next_s == CNT_FULL);

    // Frame FSM, shifters, interrupt handshake and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_ARM;
            arm_cnt_r   <= 2'd0;
            rx_sr_r     <= {DATA_BITS{1'b0}};
            tx_sr_r     <= {(DATA_BITS-1){1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            miso_r      <= 1'b0;
            miso_oe_r   <= 1'b0;
            rx_data_r   <= {DATA_BITS{1'b0}};
            rx_int_r    <= 1'b0;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;

            // A completing word beats a simultaneous clear; the clear still
            // keeps overrun from being raised.
            if (word_done_s) begin
                rx_data_r <= rx_sr_next_s;
                rx_int_r  <= 1'b1;
                overrun_r <= ~rx_interrupt_clear & (overrun_r | rx_int_r);
            end else if (rx_interrupt_clear) begin
                rx_int_r  <= 1'b0;
                overrun_r <= 1'b0;
            end else begin
                rx_int_r  <= rx_int_r;
                overrun_r <= overrun_r;
            end

            case (state_r)
                ST_ARM: begin
                    // The synchroniser holds its reset value for a few cycles,
                    // so only trust cs_n once real pin samples have arrived.
                    if (arm_cnt_r != 2'd3) begin
                        arm_cnt_r <= arm_cnt_r + 2'd1;
                    end else if (cs_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_ARM;
                    end
                end
                ST_IDLE: begin
                    if (cs_fall_s) begin
                        tx_sr_r   <= tx_data[DATA_BITS-2:0];
                        cnt_r     <= {CNT_W{1'b0}};
                        miso_r    <= tx_data[DATA_BITS-1];
                        miso_oe_r <= 1'b1;
                        state_r   <= ST_SHIFT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    rx_sr_r <= rx_sr_next_s;
                    cnt_r   <= cnt_next_s;
                    if (cs_rise_s) begin
                        miso_oe_r <= 1'b0;
                        miso_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                        if (cnt_next_s != CNT_FULL) begin
                            frame_err_r <= 1'b1;
                        end else begin
                            frame_err_r <= 1'b0;
                        end
                    end else if (sclk_fall_s) begin
                        // Zero fill means MISO reads 0 once the word is exhausted.
                        miso_r  <= tx_sr_r[DATA_BITS-2];
                        tx_sr_r <= {tx_sr_r[DATA_BITS-3:0], 1'b0};
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                default: begin
                    state_r <= ST_ARM;
                end
            endcase
        end
    end

    assign miso         = miso_r;
    assign miso_oe      = miso_oe_r;
    assign rx_data      = rx_data_r;
    assign rx_interrupt = rx_int_r;
    assign overrun      = overrun_r;
    assign frame_err    = frame_err_r;

endmodule
